// File: rtl/centroid_pkg.sv
// centroid_pkg: shared FSM state type, default widths and a parameter sanity check
// for the centroid_track block.
package centroid_pkg;

  localparam int DEF_IMG_W    = 1280;
  localparam int DEF_IMG_H    = 720;
  localparam int DEF_XW       = 11;
  localparam int DEF_YW       = 10;
  localparam int DEF_MW       = 20;
  localparam int DEF_SW       = 32;
  localparam int DEF_MIN_AREA = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  // True when the coordinate, area and moment widths can hold a full frame.
  function automatic bit widths_ok(input int img_w, input int img_h, input int xw,
                                   input int yw, input int mw, input int sw);
    longint max_area;
    longint max_sum;
    bit     ok;
    max_area = longint'(img_w) * longint'(img_h);
    max_sum  = max_area * longint'(img_w - 1);
    ok = ((longint'(1) << xw) >= longint'(img_w)) &&
         ((longint'(1) << yw) >= longint'(img_h)) &&
         ((longint'(1) << mw) >  max_area) &&
         ((sw >= 63) || (max_sum < (longint'(1) << sw)));
    return ok;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, SW-bit dividend by MW-bit divisor, one quotient
// bit per enabled cycle. The start cycle already resolves the first bit, so a
// division occupies exactly SW enabled cycles; quotient is valid after done.
module seq_divider #(
  parameter int SW = 32,
  parameter int MW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [MW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] quotient
);

  localparam int CW = $clog2(SW + 1);

  logic [MW-1:0] rem_q, rem_d;
  logic [SW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  logic [MW-1:0] step_rem;
  logic [SW-1:0] step_src;
  logic [MW:0]   trial;
  logic [MW:0]   rem_wide;
  logic          qbit;
  logic          unused_rem_msb;

  // One restoring step, fed either by the running remainder or a fresh dividend.
  always_comb begin
    step_rem = busy_q ? rem_q : '0;
    step_src = busy_q ? quo_q : dividend;
    trial    = {step_rem, step_src[SW-1]};
    qbit     = (trial >= {1'b0, divisor});
    rem_wide = qbit ? (trial - {1'b0, divisor}) : trial;
  end

  // A remainder is always below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_wide[MW];

  // Sequencing: load on start when idle, then shift until the count runs out.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      rem_d = rem_wide[MW-1:0];
      quo_d = {quo_q[SW-2:0], qbit};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_d = 1'b0;
    end else if (start) begin
      rem_d  = rem_wide[MW-1:0];
      quo_d  = {dividend[SW-2:0], qbit};
      cnt_d  = CW'(SW - 1);
      busy_d = 1'b1;
    end
  end

  // Divider state registers, frozen while ce is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (ce) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q & (cnt_q == CW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/centroid_track.sv
// centroid_track: per-frame mask moments, area and bounding box; centroid via a
// shared sequential divider at end of frame. Bounding-box tracking is built only
// when the macro CENTROID_BBOX_EN is defined; otherwise the bbox outputs are 0.
module centroid_track
  import centroid_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int MW       = DEF_MW,
  parameter int SW       = DEF_SW,
  parameter int MIN_AREA = DEF_MIN_AREA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          de,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          mask,
  output logic [XW-1:0] xcent,
  output logic [YW-1:0] ycent,
  output logic [XW-1:0] xmin,
  output logic [XW-1:0] xmax,
  output logic [YW-1:0] ymin,
  output logic [YW-1:0] ymax,
  output logic [MW-1:0] area,
  output logic          found,
  output logic          valid,
  output logic          overrun
);

  if (!widths_ok(IMG_W, IMG_H, XW, YW, MW, SW)) begin : g_bad_widths
    $error("centroid_track: coordinate/area/moment widths too small for the image size");
  end

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x_pos_q, x_pos_d;
  logic [YW-1:0] y_pos_q, y_pos_d;
  logic          prev_vsync_q, prev_vsync_d;
  logic [MW-1:0] m_q, m_d, hold_m_q, hold_m_d;
  logic [SW-1:0] sx_q, sx_d, hold_sx_q, hold_sx_d;
  logic [SW-1:0] sy_q, sy_d, hold_sy_q, hold_sy_d;
  state_t        state_q, state_d;
  logic [XW-1:0] xq_q, xq_d, xcent_q, xcent_d;
  logic [YW-1:0] ycent_q, ycent_d;
  logic [MW-1:0] area_q, area_d;
  logic          found_q, found_d, valid_q, valid_d;

  logic          eof, snap;
  logic          div_start, div_busy, div_done;
  logic [SW-1:0] div_dividend, div_quo;
  logic          unused_inputs;

  assign eof           = ce & vsync & ~prev_vsync_q;
  assign snap          = eof & (state_q == IDLE);
  assign unused_inputs = hsync ^ (^div_quo[SW-1:XW]);

  // Position counters, moment accumulators and the end-of-frame snapshot.
  always_comb begin
    x_pos_d      = x_pos_q;
    y_pos_d      = y_pos_q;
    prev_vsync_d = prev_vsync_q;
    m_d          = m_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    hold_m_d     = hold_m_q;
    hold_sx_d    = hold_sx_q;
    hold_sy_d    = hold_sy_q;
    if (ce) begin
      prev_vsync_d = vsync;
      if (vsync) begin
        x_pos_d = '0;
        y_pos_d = '0;
      end else if (de) begin
        if (x_pos_q == X_LAST) begin
          x_pos_d = '0;
          y_pos_d = (y_pos_q == Y_LAST) ? '0 : y_pos_q + 1'b1;
        end else begin
          x_pos_d = x_pos_q + 1'b1;
        end
      end
      if (eof) begin
        m_d  = '0;
        sx_d = '0;
        sy_d = '0;
      end else if (de && mask) begin
        m_d  = m_q + 1'b1;
        sx_d = sx_q + SW'(x_pos_q);
        sy_d = sy_q + SW'(y_pos_q);
      end
      if (snap) begin
        hold_m_d  = m_q;
        hold_sx_d = sx_q;
        hold_sy_d = sy_q;
      end
    end
  end

  // Result sequencer: x division, y division, then publish with a valid strobe.
  always_comb begin
    state_d      = state_q;
    xq_d         = xq_q;
    xcent_d      = xcent_q;
    ycent_d      = ycent_q;
    area_d       = area_q;
    found_d      = found_q;
    valid_d      = 1'b0;
    div_start    = 1'b0;
    div_dividend = hold_sx_q;
    if (ce) begin
      case (state_q)
        IDLE: if (eof) state_d = DIV_X;
        DIV_X: begin
          div_start = ~div_busy;
          if (div_done) state_d = DIV_Y;
        end
        DIV_Y: begin
          div_dividend = hold_sy_q;
          div_start    = ~div_busy;
          // The x quotient is still in the divider until y starts this cycle.
          if (!div_busy) xq_d = div_quo[XW-1:0];
          if (div_done) state_d = DONE;
        end
        DONE: begin
          valid_d = 1'b1;
          area_d  = hold_m_q;
          if ((hold_m_q >= MW'(MIN_AREA)) && (hold_m_q != '0)) begin
            found_d = 1'b1;
            xcent_d = xq_q;
            ycent_d = div_quo[YW-1:0];
          end else begin
            found_d = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // All core registers; valid is a strobe so it is refreshed every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      prev_vsync_q <= 1'b0;
      m_q          <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      hold_m_q     <= '0;
      hold_sx_q    <= '0;
      hold_sy_q    <= '0;
      state_q      <= IDLE;
      xq_q         <= '0;
      xcent_q      <= '0;
      ycent_q      <= '0;
      area_q       <= '0;
      found_q      <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      prev_vsync_q <= prev_vsync_d;
      m_q          <= m_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      hold_m_q     <= hold_m_d;
      hold_sx_q    <= hold_sx_d;
      hold_sy_q    <= hold_sy_d;
      state_q      <= state_d;
      xq_q         <= xq_d;
      xcent_q      <= xcent_d;
      ycent_q      <= ycent_d;
      area_q       <= area_d;
      found_q      <= found_d;
      valid_q      <= valid_d;
    end
  end

  seq_divider #(.SW(SW), .MW(MW)) u_div (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (hold_m_q),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

`ifdef CENTROID_BBOX_EN
  logic [XW-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [YW-1:0] by_min_q, by_min_d, by_max_q, by_max_d;
  logic [XW-1:0] hx_min_q, hx_min_d, hx_max_q, hx_max_d;
  logic [YW-1:0] hy_min_q, hy_min_d, hy_max_q, hy_max_d;
  logic [XW-1:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
  logic [YW-1:0] oy_min_q, oy_min_d, oy_max_q, oy_max_d;

  // Bounding box: running min/max, snapshot at eof, published in DONE.
  always_comb begin
    bx_min_d = bx_min_q;  bx_max_d = bx_max_q;
    by_min_d = by_min_q;  by_max_d = by_max_q;
    hx_min_d = hx_min_q;  hx_max_d = hx_max_q;
    hy_min_d = hy_min_q;  hy_max_d = hy_max_q;
    ox_min_d = ox_min_q;  ox_max_d = ox_max_q;
    oy_min_d = oy_min_q;  oy_max_d = oy_max_q;
    if (ce) begin
      if (eof) begin
        bx_min_d = '1;  bx_max_d = '0;
        by_min_d = '1;  by_max_d = '0;
      end else if (de && mask) begin
        if (x_pos_q < bx_min_q) bx_min_d = x_pos_q;
        if (x_pos_q > bx_max_q) bx_max_d = x_pos_q;
        if (y_pos_q < by_min_q) by_min_d = y_pos_q;
        if (y_pos_q > by_max_q) by_max_d = y_pos_q;
      end
      if (snap) begin
        hx_min_d = bx_min_q;  hx_max_d = bx_max_q;
        hy_min_d = by_min_q;  hy_max_d = by_max_q;
      end
      if (state_q == DONE) begin
        if (hold_m_q == '0) begin
          ox_min_d = '0;  ox_max_d = '0;
          oy_min_d = '0;  oy_max_d = '0;
        end else begin
          ox_min_d = hx_min_q;  ox_max_d = hx_max_q;
          oy_min_d = hy_min_q;  oy_max_d = hy_max_q;
        end
      end
    end
  end

  // Bounding-box registers; a cleared running box is min all-ones, max zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      bx_min_q <= '1;  bx_max_q <= '0;
      by_min_q <= '1;  by_max_q <= '0;
      hx_min_q <= '0;  hx_max_q <= '0;
      hy_min_q <= '0;  hy_max_q <= '0;
      ox_min_q <= '0;  ox_max_q <= '0;
      oy_min_q <= '0;  oy_max_q <= '0;
    end else begin
      bx_min_q <= bx_min_d;  bx_max_q <= bx_max_d;
      by_min_q <= by_min_d;  by_max_q <= by_max_d;
      hx_min_q <= hx_min_d;  hx_max_q <= hx_max_d;
      hy_min_q <= hy_min_d;  hy_max_q <= hy_max_d;
      ox_min_q <= ox_min_d;  ox_max_q <= ox_max_d;
      oy_min_q <= oy_min_d;  oy_max_q <= oy_max_d;
    end
  end

  assign xmin = ox_min_q;
  assign xmax = ox_max_q;
  assign ymin = oy_min_q;
  assign ymax = oy_max_q;
`else
  assign xmin = '0;
  assign xmax = '0;
  assign ymin = '0;
  assign ymax = '0;
`endif

  assign xcent   = xcent_q;
  assign ycent   = ycent_q;
  assign area    = area_q;
  assign found   = found_q;
  assign valid   = valid_q;
  assign overrun = eof & (state_q != IDLE);

endmodule
